counter_scoreboard: RTL and testbench
=====================================

COUNTER_SCOREBOARD -- requirements
Module: counter_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter data width; legal range 2..32.
REQ-002 SHALL have parameter ERR_W, default 8: error-counter width.
REQ-003 SHALL have parameter CYC_W, default 16: cycle-stamp width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have stimulus inputs enable (1), mode (2) and D (WIDTH): the stimulus driven to the DUT.
REQ-007 SHALL have observed inputs Q (WIDTH), rco (1) and load (1): the DUT outputs.
REQ-008 SHALL have input clear  in  1  synchronous statistics clear.
REQ-009 SHALL have outputs q_exp (WIDTH), rco_exp (1) and load_exp (1): the expected DUT outputs.
REQ-010 SHALL have outputs q_fail, rco_fail and load_fail (1 each): registered per-cycle mismatch flags.
REQ-011 SHALL have output err_count  out  ERR_W  saturating mismatch-cycle count.
REQ-012 SHALL have outputs first_fail_cycle (CYC_W) and first_fail_mask (3, bit order {load,rco,Q}): capture of the first failure.
REQ-013 SHALL have output state  out  2  current checker state.

Function
REQ-014 Mode encoding SHALL be: 2'b00 count +1; 2'b01 count -1; 2'b10 count -3; 2'b11 load D.
REQ-015 Model update SHALL be {rco_exp,q_exp} <= {1'b0,q_exp} op step, computed in WIDTH+1 bits; the carry/borrow bit forms rco_exp, and q_exp wraps modulo 2^WIDTH.
REQ-016 In load mode the model SHALL set q_exp=D, rco_exp=0 and load_exp=1; in all other modes load_exp=0.
REQ-017 With enable=0, the model SHALL set q_exp, rco_exp and load_exp to 0.
REQ-018 At each edge, the DUT outputs sampled at that edge SHALL be compared against the expected values registered at the previous edge, giving one cycle of latency.
REQ-019 Any X or Z on an observed bit SHALL count as a mismatch in simulation.
REQ-020 The FSM SHALL have states IDLE=0, CHECK=1, FAIL=2.
REQ-021 The FSM SHALL move IDLE->CHECK on the first edge with enable=1, and CHECK->FAIL on the first mismatch; FAIL SHALL be sticky.
REQ-022 In IDLE, the fail flags SHALL be held at 0 and err_count SHALL not increment.
REQ-023 err_count SHALL increment by 1 per cycle with any mismatch, and SHALL saturate at all-ones.
REQ-024 The cycle stamp SHALL count edges since leaving IDLE and SHALL saturate.
REQ-025 first_fail_cycle and first_fail_mask SHALL be loaded only on the CHECK->FAIL transition.
REQ-026 clear=1 SHALL return the FSM to IDLE and zero err_count, the cycle stamp, the capture registers and the fail flags; clear SHALL win over a simultaneous mismatch.
REQ-027 The model registers SHALL continue to follow stimulus during clear.

Reset
REQ-028 Asserting reset (low) SHALL immediately force all outputs to 0 and state to IDLE, including mid-count or while in FAIL.
REQ-029 Reset release SHALL take effect on the first rising clk edge with reset=1.

Configuration
REQ-030 With RCO_HALF_CYCLE_EN defined, rco_exp SHALL be high only from the rising edge to the following falling edge, and DUT rco SHALL be sampled and compared at the falling edge; rco_fail SHALL still be reported on the next rising edge.
REQ-031 Without RCO_HALF_CYCLE_EN, rco_exp SHALL be a full-cycle level compared at the rising edge, and no falling-edge logic SHALL exist.

Structure
REQ-032 Package counter_pkg SHALL hold the mode encodings, the FSM state encodings and the fail-mask bit indices.
REQ-033 Sub-module counter_ref_model SHALL contain the expected-value model: the counter arithmetic, rco and load generation, and the half-cycle rco logic.
REQ-034 The top level SHALL contain the comparison logic, the FSM and the statistics.

Verification
REQ-035 Wrap-up: WIDTH=4, load D=4'hE, then mode +1 for 3 cycles with DUT correct -> q_exp sequence E,F,0,1; rco_exp=1 on the 0 cycle; err_count=0; state=CHECK.
REQ-036 Borrow: load 4'h1, then mode -3 -> q_exp=4'hE, rco_exp=1; load_exp=1 only in the load cycle.
REQ-037 Injected fault: DUT Q forced to 4'h5 when q_exp=4'h6 at cycle 10 -> q_fail=1 for one cycle; state=FAIL; first_fail_cycle=10; first_fail_mask=3'b001; err_count=1.
REQ-038 Saturation: ERR_W=2 with 5 mismatch cycles -> err_count=3; capture registers unchanged after the first failure.
REQ-039 Clear/reset: clear together with a mismatch -> state=IDLE, err_count=0; asserting reset mid-count -> all outputs 0 asynchronously.
REQ-040 RCO_HALF_CYCLE_EN: DUT rco held for a full cycle on a wrap -> rco_fail=1; DUT rco as a half-cycle pulse -> no failure.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the counter scoreboard: stimulus modes, checker
// states and the bit positions of the first-failure mask.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_INC  = 2'b00,
    MODE_DEC1 = 2'b01,
    MODE_DEC3 = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAIL  = 2'd2
  } state_e;

  localparam int unsigned MASK_W    = 3;
  localparam int unsigned MASK_Q    = 0;
  localparam int unsigned MASK_RCO  = 1;
  localparam int unsigned MASK_LOAD = 2;

endpackage

// File: rtl/counter_scoreboard_if.sv
// Stimulus, observed DUT outputs and checker results for the counter
// scoreboard. master = environment side, slave = scoreboard side.
interface counter_scoreboard_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8,
  parameter int unsigned CYC_W = 16
);

  // stimulus driven to the DUT
  logic              enable;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  D;
  // DUT outputs under observation
  logic [WIDTH-1:0]  Q;
  logic              rco;
  logic              load;
  // statistics control
  logic              clear;
  // checker results
  logic [WIDTH-1:0]  q_exp;
  logic              rco_exp;
  logic              load_exp;
  logic              q_fail;
  logic              rco_fail;
  logic              load_fail;
  logic [ERR_W-1:0]  err_count;
  logic [CYC_W-1:0]  first_fail_cycle;
  logic [MASK_W-1:0] first_fail_mask;
  logic [1:0]        state;

  modport master (
    output enable, mode, D, Q, rco, load, clear,
    input  q_exp, rco_exp, load_exp, q_fail, rco_fail, load_fail,
           err_count, first_fail_cycle, first_fail_mask, state
  );

  modport slave (
    input  enable, mode, D, Q, rco, load, clear,
    output q_exp, rco_exp, load_exp, q_fail, rco_fail, load_fail,
           err_count, first_fail_cycle, first_fail_mask, state
  );

endinterface

// File: rtl/counter_ref_model.sv
// Expected-value model of the counter: wrap-around arithmetic with carry /
// borrow on rco, load indication, and all-zero outputs while disabled.
// RCO_HALF_CYCLE_EN: rco_exp is only high from the rising edge to the
// following falling edge.
module counter_ref_model
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_exp,
  output logic             rco_exp,
  output logic             load_exp
);

  localparam int unsigned EXT_W = WIDTH + 1;

  logic [WIDTH-1:0] q_d, q_q;
  logic             rco_d, rco_q;
  logic             load_d, load_q;
  logic [EXT_W-1:0] ext_c, sum_c;

  // next expected value; the extra top bit carries the carry/borrow
  always_comb begin
    q_d    = '0;
    rco_d  = 1'b0;
    load_d = 1'b0;
    ext_c  = {1'b0, q_q};
    sum_c  = ext_c;
    if (enable) begin
      case (mode)
        MODE_INC:  sum_c = ext_c + EXT_W'(1);
        MODE_DEC1: sum_c = ext_c - EXT_W'(1);
        MODE_DEC3: sum_c = ext_c - EXT_W'(3);
        default:   sum_c = {1'b0, d};
      endcase
      q_d    = sum_c[WIDTH-1:0];
      rco_d  = sum_c[WIDTH];
      load_d = (mode == MODE_LOAD);
    end
  end

  // model registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      load_q <= load_d;
    end
  end

  assign q_exp    = q_q;
  assign load_exp = load_q;

`ifdef RCO_HALF_CYCLE_EN
  // Phase tracking: the two toggles differ only between a rising edge and
  // the next falling edge, which gates rco to the high clock phase.
  logic pos_tog_d, pos_tog_q;
  logic neg_tog_d, neg_tog_q;

  // next toggle values
  always_comb begin
    pos_tog_d = ~pos_tog_q;
    neg_tog_d = pos_tog_q;
  end

  // rising-edge phase toggle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pos_tog_q <= 1'b0;
    else        pos_tog_q <= pos_tog_d;
  end

  // falling-edge follower of the rising-edge toggle
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) neg_tog_q <= 1'b0;
    else        neg_tog_q <= neg_tog_d;
  end

  assign rco_exp = rco_q & (pos_tog_q ^ neg_tog_q);
`else
  assign rco_exp = rco_q;
`endif

endmodule

// File: rtl/counter_scoreboard.sv
// Counter scoreboard top: compares observed DUT outputs against the
// reference model one cycle later, tracks checker state and failure
// statistics. RCO_HALF_CYCLE_EN adds a falling-edge rco comparison.
module counter_scoreboard
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8,
  parameter int unsigned CYC_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  counter_scoreboard_if.slave sb
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  logic [WIDTH-1:0] q_exp;
  logic             rco_exp;
  logic             load_exp;

  counter_ref_model #(.WIDTH(WIDTH)) u_model (
    .clk      (clk),
    .reset    (reset),
    .enable   (sb.enable),
    .mode     (sb.mode),
    .d        (sb.D),
    .q_exp    (q_exp),
    .rco_exp  (rco_exp),
    .load_exp (load_exp)
  );

`ifdef RCO_HALF_CYCLE_EN
  logic rco_neg_mis_d, rco_neg_mis_q;

  // rco pulse compared in the high phase
  always_comb begin
    rco_neg_mis_d = (sb.rco !== rco_exp);
  end

  // falling-edge rco mismatch, consumed at the next rising edge
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) rco_neg_mis_q <= 1'b0;
    else        rco_neg_mis_q <= rco_neg_mis_d;
  end
`endif

  logic              q_mis_c, rco_mis_c, load_mis_c, any_mis_c;
  logic [MASK_W-1:0] mis_mask_c;

  // rising-edge comparison; X/Z on an observed bit counts as a mismatch
  always_comb begin
    q_mis_c    = (sb.Q !== q_exp);
    rco_mis_c  = (sb.rco !== rco_exp);
`ifdef RCO_HALF_CYCLE_EN
    rco_mis_c  = rco_mis_c | rco_neg_mis_q;
`endif
    load_mis_c = (sb.load !== load_exp);
    mis_mask_c = '0;
    mis_mask_c[MASK_Q]    = q_mis_c;
    mis_mask_c[MASK_RCO]  = rco_mis_c;
    mis_mask_c[MASK_LOAD] = load_mis_c;
    any_mis_c  = |mis_mask_c;
  end

  state_e            state_d, state_q;
  logic [ERR_W-1:0]  err_d, err_q;
  logic [CYC_W-1:0]  cyc_d, cyc_q, cyc_inc_c;
  logic [CYC_W-1:0]  ffc_d, ffc_q;
  logic [MASK_W-1:0] ffm_d, ffm_q;
  logic              q_fail_d, q_fail_q;
  logic              rco_fail_d, rco_fail_q;
  logic              load_fail_d, load_fail_q;

  // checker FSM, cycle stamp, error count and first-failure capture
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    cyc_d       = cyc_q;
    ffc_d       = ffc_q;
    ffm_d       = ffm_q;
    q_fail_d    = 1'b0;
    rco_fail_d  = 1'b0;
    load_fail_d = 1'b0;
    cyc_inc_c   = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CYC_W'(1);

    if (sb.clear) begin
      state_d = ST_IDLE;
      err_d   = '0;
      cyc_d   = '0;
      ffc_d   = '0;
      ffm_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cyc_d = '0;
          if (sb.enable) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          cyc_d = cyc_inc_c;
          if (any_mis_c) begin
            state_d = ST_FAIL;
            ffc_d   = cyc_inc_c;
            ffm_d   = mis_mask_c;
          end
        end
        ST_FAIL: cyc_d = cyc_inc_c;
        default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_IDLE) begin
        q_fail_d    = q_mis_c;
        rco_fail_d  = rco_mis_c;
        load_fail_d = load_mis_c;
        if (any_mis_c && (err_q != ERR_MAX)) err_d = err_q + ERR_W'(1);
      end
    end
  end

  // checker registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      err_q       <= '0;
      cyc_q       <= '0;
      ffc_q       <= '0;
      ffm_q       <= '0;
      q_fail_q    <= 1'b0;
      rco_fail_q  <= 1'b0;
      load_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      cyc_q       <= cyc_d;
      ffc_q       <= ffc_d;
      ffm_q       <= ffm_d;
      q_fail_q    <= q_fail_d;
      rco_fail_q  <= rco_fail_d;
      load_fail_q <= load_fail_d;
    end
  end

  assign sb.q_exp            = q_exp;
  assign sb.rco_exp          = rco_exp;
  assign sb.load_exp         = load_exp;
  assign sb.q_fail           = q_fail_q;
  assign sb.rco_fail         = rco_fail_q;
  assign sb.load_fail        = load_fail_q;
  assign sb.err_count        = err_q;
  assign sb.first_fail_cycle = ffc_q;
  assign sb.first_fail_mask  = ffm_q;
  assign sb.state            = state_q;

endmodule

// File: tb/tb_counter_scoreboard.sv
// Directed table-driven bench for counter_scoreboard (WIDTH=4, ERR_W=2).
// Each row drives stimulus and DUT-observed values, lets one rising edge
// pass and compares every scoreboard output against hand-computed values.
module tb_counter_scoreboard;

  localparam logic       H    = 1'b1;
  localparam logic       L    = 1'b0;
  localparam logic [1:0] INC  = 2'b00;
  localparam logic [1:0] DEC1 = 2'b01;
  localparam logic [1:0] DEC3 = 2'b10;
  localparam logic [1:0] LD   = 2'b11;
  localparam logic [1:0] SI   = 2'd0;
  localparam logic [1:0] SC   = 2'd1;
  localparam logic [1:0] SF   = 2'd2;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  d;
    logic [3:0]  q;
    logic        rco;
    logic        load;
    logic        clr;
    logic        drop;
    logic [3:0]  qe;
    logic        re;
    logic        le;
    logic        qf;
    logic        rf;
    logic        lf;
    logic [1:0]  err;
    logic [1:0]  st;
    logic [15:0] ffc;
    logic [2:0]  mask;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  counter_scoreboard_if #(.WIDTH(4), .ERR_W(2), .CYC_W(16)) sbif ();

  counter_scoreboard #(.WIDTH(4), .ERR_W(2), .CYC_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, " q_exp"},            32'(sbif.q_exp),            32'(v.qe));
    check({tag, " rco_exp"},          32'(sbif.rco_exp),          32'(v.re));
    check({tag, " load_exp"},         32'(sbif.load_exp),         32'(v.le));
    check({tag, " q_fail"},           32'(sbif.q_fail),           32'(v.qf));
    check({tag, " rco_fail"},         32'(sbif.rco_fail),         32'(v.rf));
    check({tag, " load_fail"},        32'(sbif.load_fail),        32'(v.lf));
    check({tag, " err_count"},        32'(sbif.err_count),        32'(v.err));
    check({tag, " state"},            32'(sbif.state),            32'(v.st));
    check({tag, " first_fail_cycle"}, 32'(sbif.first_fail_cycle), 32'(v.ffc));
    check({tag, " first_fail_mask"},  32'(sbif.first_fail_mask),  32'(v.mask));
  endtask

  // drive one row at posedge+1, wait one rising edge, check at posedge+1
  task automatic apply(input string tag, input vec_t v);
    sbif.enable = v.en;
    sbif.mode   = v.mode;
    sbif.D      = v.d;
    sbif.Q      = v.q;
    sbif.rco    = v.rco;
    sbif.load   = v.load;
    sbif.clear  = v.clr;
`ifdef RCO_HALF_CYCLE_EN
    if (v.drop) begin
      @(negedge clk);
      #1;
      sbif.rco = 1'b0;
    end
`endif
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  vec_t tbl [22];
  vec_t zv;
  vec_t rel;
`ifdef RCO_HALF_CYCLE_EN
  vec_t hv [6];
`endif

  initial begin
    errors = 0;
    checks = 0;
    //          en mode  d      q      rco load clr drop  qe     re le  qf rf lf  err   st  ffc     mask
    zv      = '{L, INC,  4'h0,  4'h0,  L,  L,   L,  H,    4'h0,  L, L,  L, L, L,  2'd0, SI, 16'd0,  3'b000};
    // wrap-up: load E then +1 x3
    tbl[0]  = '{H, LD,   4'hE,  4'h0,  L,  L,   L,  H,    4'hE,  L, H,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    tbl[1]  = '{H, INC,  4'h0,  4'hE,  L,  H,   L,  H,    4'hF,  L, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    tbl[2]  = '{H, INC,  4'h0,  4'hF,  L,  L,   L,  H,    4'h0,  H, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    tbl[3]  = '{H, INC,  4'h0,  4'h0,  H,  L,   L,  H,    4'h1,  L, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    // borrow: load 1 then -3, then -1
    tbl[4]  = '{H, LD,   4'h1,  4'h1,  L,  L,   L,  H,    4'h1,  L, H,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    tbl[5]  = '{H, DEC3, 4'h0,  4'h1,  L,  H,   L,  H,    4'hE,  H, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    tbl[6]  = '{H, DEC1, 4'h0,  4'hE,  H,  L,   L,  H,    4'hD,  L, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    // disabled model outputs zero
    tbl[7]  = '{L, INC,  4'h0,  4'hD,  L,  L,   L,  H,    4'h0,  L, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    // injected fault at cycle 10: Q=5 while 6 expected
    tbl[8]  = '{H, LD,   4'h5,  4'h0,  L,  L,   L,  H,    4'h5,  L, H,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    tbl[9]  = '{H, INC,  4'h0,  4'h5,  L,  H,   L,  H,    4'h6,  L, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    tbl[10] = '{H, INC,  4'h0,  4'h5,  L,  L,   L,  H,    4'h7,  L, L,  H, L, L,  2'd1, SF, 16'd10, 3'b001};
    tbl[11] = '{H, INC,  4'h0,  4'h7,  L,  L,   L,  H,    4'h8,  L, L,  L, L, L,  2'd1, SF, 16'd10, 3'b001};
    // saturation of the 2-bit error counter, capture stays put
    tbl[12] = '{H, INC,  4'h0,  4'h0,  L,  H,   L,  H,    4'h9,  L, L,  H, L, H,  2'd2, SF, 16'd10, 3'b001};
    tbl[13] = '{H, INC,  4'h0,  4'h9,  H,  L,   L,  H,    4'hA,  L, L,  L, H, L,  2'd3, SF, 16'd10, 3'b001};
    tbl[14] = '{H, INC,  4'h0,  4'h0,  L,  L,   L,  H,    4'hB,  L, L,  H, L, L,  2'd3, SF, 16'd10, 3'b001};
    tbl[15] = '{H, INC,  4'h0,  4'hB,  L,  H,   L,  H,    4'hC,  L, L,  L, L, H,  2'd3, SF, 16'd10, 3'b001};
    tbl[16] = '{H, INC,  4'h0,  4'hC,  L,  L,   L,  H,    4'hD,  L, L,  L, L, L,  2'd3, SF, 16'd10, 3'b001};
    // clear wins over a mismatch; model keeps counting
    tbl[17] = '{H, INC,  4'h0,  4'h0,  L,  L,   H,  H,    4'hE,  L, L,  L, L, L,  2'd0, SI, 16'd0,  3'b000};
    tbl[18] = '{H, INC,  4'h0,  4'hE,  L,  L,   L,  H,    4'hF,  L, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    tbl[19] = '{H, INC,  4'h0,  4'hF,  L,  L,   L,  H,    4'h0,  H, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    // missing rco is the first failure, then an unknown Q
    tbl[20] = '{H, INC,  4'h0,  4'h0,  L,  L,   L,  H,    4'h1,  L, L,  L, H, L,  2'd1, SF, 16'd2,  3'b010};
    tbl[21] = '{H, INC,  4'h0,  4'bxxxx, L, L,  L,  H,    4'h2,  L, L,  H, L, L,  2'd2, SF, 16'd2,  3'b010};
    // first edge after reset release
    rel     = '{H, LD,   4'h3,  4'h0,  L,  L,   L,  H,    4'h3,  L, H,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
`ifdef RCO_HALF_CYCLE_EN
    hv[0]   = '{H, LD,   4'hF,  4'h3,  L,  H,   L,  H,    4'hF,  L, H,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    hv[1]   = '{H, INC,  4'h0,  4'hF,  L,  H,   L,  H,    4'h0,  H, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    hv[2]   = '{H, INC,  4'h0,  4'h0,  H,  L,   L,  L,    4'h1,  L, L,  L, H, L,  2'd1, SF, 16'd3,  3'b010};
    hv[3]   = '{H, LD,   4'hF,  4'h1,  L,  L,   H,  H,    4'hF,  L, H,  L, L, L,  2'd0, SI, 16'd0,  3'b000};
    hv[4]   = '{H, INC,  4'h0,  4'hF,  L,  H,   L,  H,    4'h0,  H, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
    hv[5]   = '{H, INC,  4'h0,  4'h0,  H,  L,   L,  H,    4'h1,  L, L,  L, L, L,  2'd0, SC, 16'd0,  3'b000};
`endif

    reset       = 1'b0;
    sbif.enable = 1'b0;
    sbif.mode   = INC;
    sbif.D      = 4'h0;
    sbif.Q      = 4'h0;
    sbif.rco    = 1'b0;
    sbif.load   = 1'b0;
    sbif.clear  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", zv);

    reset = 1'b1;
    for (int i = 0; i < 22; i++) apply($sformatf("row%0d", i), tbl[i]);

    // async reset while in FAIL and counting
    sbif.enable = 1'b1;
    sbif.mode   = INC;
    sbif.Q      = 4'h2;
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_rst", zv);
    @(posedge clk);
    #1;
    check_outs("rst_hold", zv);
    reset = 1'b1;
    apply("rst_release", rel);

`ifdef RCO_HALF_CYCLE_EN
    for (int i = 0; i < 6; i++) apply($sformatf("half%0d", i), hv[i]);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
